// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 default timing, frame-total helpers and sync polarity constants
package vga_timing_pkg;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam bit POL_LOW  = 1'b0;
   localparam bit POL_HIGH = 1'b1;
   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic sof;
      logic eol;
   } vid_t;
   function automatic int h_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction
   function automatic int v_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: D-deep shift register with async reset and synchronous flush
module vga_delay_line #(
   parameter int W = 1,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   if (D == 0) begin : g_wire
      assign q = d;
   end else begin : g_sr
      logic [W-1:0] sr [D];
      always_ff @(posedge clk or posedge rst)
         if (rst) sr <= '{default: '0};
         else if (flush) sr <= '{default: '0};
         else begin
            sr[0] <= d;
            for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
         end
      assign q = sr[D-1];
   end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, stage-0 strobes and PIPE-delayed sync/de/sof/eol outputs
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = POL_LOW,
   parameter bit VS_POL   = POL_LOW,
   parameter int CW       = 10,
   parameter int PIPE     = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic          req,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic          sof,
   output logic          eol
);
   localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   if ((64'd1 << CW) < 64'(H_TOT) || (64'd1 << CW) < 64'(V_TOT)) begin : g_cw_err
      $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
   end
   if (PIPE < 0 || PIPE > 4) begin : g_pipe_err
      $error("vga_timing_gen: PIPE must be 0..4");
   end
   // inclusive bounds keep every constant representable even when a total equals 2^CW
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
   localparam logic [CW-1:0] HA_LAST  = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0] VA_LAST  = CW'(V_ACTIVE - 1);
   localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
   logic [CW-1:0] hc, vc;
   logic          h_wrap, v_wrap;
   vid_t          s0_nxt, s0, s0_d;
   assign h_wrap = hc == H_LAST;
   assign v_wrap = vc == V_LAST;
   always_comb begin
      s0_nxt     = '0;
      s0_nxt.de  = hc <= HA_LAST && vc <= VA_LAST;
      s0_nxt.hs  = hc >= HS_FIRST && hc <= HS_LAST;
      s0_nxt.vs  = vc >= VS_FIRST && vc <= VS_LAST;
      s0_nxt.sof = hc == '0 && vc == '0;
      s0_nxt.eol = hc == HA_LAST && vc <= VA_LAST;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         hc <= '0;
         vc <= '0;
         s0 <= '0;
         x  <= '0;
         y  <= '0;
      end else if (!en) begin
         hc <= '0;
         vc <= '0;
         s0 <= '0;
         x  <= '0;
         y  <= '0;
      end else begin
         hc <= h_wrap ? '0 : hc + 1'b1;
         if (h_wrap) vc <= v_wrap ? '0 : vc + 1'b1;
         s0 <= s0_nxt;
         x  <= hc;
         y  <= vc;
      end
   vga_delay_line #(.W($bits(vid_t)), .D(PIPE)) u_dly (
      .clk   (clk),
      .rst   (rst),
      .flush (!en),
      .d     (s0),
      .q     (s0_d)
   );
   assign req   = s0.de;
   assign hsync = s0_d.hs ? HS_POL : ~HS_POL;
   assign vsync = s0_d.vs ? VS_POL : ~VS_POL;
   assign de    = s0_d.de;
   assign sof   = s0_d.sof;
   assign eol   = s0_d.eol;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized en/rst stimulus against a frame-position reference model
module tb_vga_timing_gen;
   localparam int CW = 10;
   localparam int PIPE = 2;
   localparam int HT = 8;
   localparam int FRAME = 48;
   typedef struct packed {
      logic req;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic hs;
      logic vs;
      logic sof;
      logic eol;
   } s0_t;
   logic clk = 1'b0, rst = 1'b0, en = 1'b0;
   logic req, hsync, vsync, de, sof, eol;
   logic req_p, hsync_p, vsync_p, de_p, sof_p, eol_p;
   logic [CW-1:0] x, y, x_p, y_p;
   s0_t hist [PIPE+1];
   int n = 0, n_tests = 0, n_fail = 0;
   int c_sof, c_de, c_vs, c_hs, c_eol, t1, t2;
   always #5 clk = ~clk;
   vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .PIPE(PIPE)) u_dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .x(x), .y(y),
      .hsync(hsync), .vsync(vsync), .de(de), .sof(sof), .eol(eol));
   vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW), .PIPE(PIPE)) u_pol (
      .clk(clk), .rst(rst), .en(en), .req(req_p), .x(x_p), .y(y_p),
      .hsync(hsync_p), .vsync(vsync_p), .de(de_p), .sof(sof_p), .eol(eol_p));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   // stage-0 values for position p within the 48-cycle frame, straight from the raster rules
   function automatic s0_t at(input int p);
      s0_t s;
      int h = p % HT;
      int v = p / HT;
      s.req = h < 4 && v < 3;
      s.x   = CW'(h);
      s.y   = CW'(v);
      s.hs  = h >= 5 && h < 7;
      s.vs  = v == 4;
      s.sof = p == 0;
      s.eol = h == 3 && v < 3;
      return s;
   endfunction
   task automatic mreset();
      n = 0;
      for (int i = 0; i <= PIPE; i++) hist[i] = '0;
   endtask
   task automatic chk_reset(input string tag);
      chk(tag, 32'({req, x, y, hsync, vsync, de, sof, eol}), 32'({1'b0, 20'd0, 1'b1, 1'b1, 3'b000}));
      chk({tag, "_pol"}, 32'({req_p, hsync_p, vsync_p, de_p, sof_p, eol_p}), 32'd0);
   endtask
   task automatic compare();
      s0_t o = hist[PIPE];
      chk("req", 32'(req), 32'(hist[0].req));
      chk("xy", 32'({x, y}), 32'({hist[0].x, hist[0].y}));
      chk("out", 32'({hsync, vsync, de, sof, eol}), 32'({~o.hs, ~o.vs, o.req, o.sof, o.eol}));
      chk("pol", 32'({hsync_p, vsync_p, de_p, sof_p, eol_p}), 32'({o.hs, o.vs, o.req, o.sof, o.eol}));
      c_sof += int'(sof);
      c_de  += int'(de);
      c_vs  += int'(!vsync);
      c_hs  += int'(!hsync);
      c_eol += int'(eol);
   endtask
   task automatic tick();
      @(posedge clk);
      if (rst || !en) mreset();
      else begin
         for (int i = PIPE; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = at(n % FRAME);
         n++;
      end
      #1 compare();
   endtask
   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1 chk_reset(tag);
      mreset();
      tick();
      rst = 1'b0;
   endtask
   initial begin
      mreset();
      #1 rst = 1'b1;
      #1 chk_reset("reset");
      tick();
      tick();
      rst = 1'b0;
      en = 1'b1;
      {c_sof, c_de, c_vs, c_hs, c_eol} = '0;
      repeat (FRAME * 2 + PIPE) tick();
      chk("sof_count", 32'(c_sof), 32'd2);
      chk("de_count", 32'(c_de), 32'd24);
      chk("vsync_low", 32'(c_vs), 32'd16);
      chk("hsync_low", 32'(c_hs), 32'd24);
      chk("eol_count", 32'(c_eol), 32'd6);
      en = 1'b0;
      tick();
      en = 1'b1;
      for (int k = 0; k < 100 && n != 10; k++) tick();
      en = 1'b0;
      tick();
      chk("flush", 32'({req, de, sof, eol, x, y, hsync, vsync}), 32'({24'd0, 2'b11}));
      tick();
      tick();
      en = 1'b1;
      t1 = -1;
      t2 = -1;
      for (int k = 0; k < 200 && t2 < 0; k++) begin
         tick();
         if (sof) begin
            if (t1 < 0) t1 = k;
            else t2 = k;
         end
      end
      chk("sof_latency", 32'(t1), 32'(PIPE));
      chk("period", 32'(t2 - t1), 32'(FRAME));
      for (int k = 0; k < 13; k++) tick();
      async_reset("midline_rst");
      {c_de, c_eol} = '0;
      tick();
      chk("no_stray", 32'({c_de, c_eol}), 32'd0);
      repeat (600) begin
         int r = int'($urandom_range(0, 31));
         en = r != 0;
         if (r == 31) async_reset("rand_rst");
         else tick();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync pulse width, in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical equivalents, in lines.
REQ-006 SHALL have parameters HS_POL 0 and VS_POL 0: asserted sync level (0 = active-low).
REQ-007 SHALL have parameter CW, default 10: counter and coordinate width.
REQ-008 SHALL have parameter PIPE, default 1, range 0..4: pixel-fetch latency compensated on the output stage.
REQ-009 SHALL have port clk, input, 1 bit: pixel clock; one clock, all logic on its rising edge.
REQ-010 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-011 SHALL have port en, input, 1 bit: run enable; low holds the block idle.
REQ-012 SHALL have port req, output, 1 bit: stage-0 active-area strobe; x/y valid.
REQ-013 SHALL have ports x and y, output, CW bits: stage-0 pixel coordinates, raw counter values.
REQ-014 SHALL have ports hsync and vsync, output, 1 bit: sync outputs, delayed by PIPE.
REQ-015 SHALL have port de, output, 1 bit: data enable, delayed by PIPE.
REQ-016 SHALL have ports sof and eol, output, 1 bit: start-of-frame and end-of-active-line pulses, delayed by PIPE.

Function
REQ-017 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL as the vertical equivalent; line order SHALL be active, FP, sync, BP.
REQ-018 Counter rules:
- hc SHALL increment each cycle en=1 and wrap H_TOTAL-1 -> 0.
- vc SHALL increment only on the hc wrap cycle and wrap V_TOTAL-1 -> 0 on the same cycle hc wraps.
REQ-019 Stage-0 signals SHALL be registered functions of the counters:
- req = (hc<H_ACTIVE && vc<V_ACTIVE).
- x=hc, y=vc.
- hs_raw asserted for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
- vs_raw asserted for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC.
REQ-020 Stage-0 pulses: sof SHALL pulse for 1 cycle at hc=0,vc=0; eol SHALL pulse for 1 cycle at hc=H_ACTIVE-1 with vc<V_ACTIVE.
REQ-021 Output timing: hsync, vsync, de, sof and eol SHALL equal their stage-0 values delayed exactly PIPE cycles; PIPE=0 SHALL make them cycle-aligned with req.
REQ-022 Sync polarity: hsync SHALL output HS_POL when asserted and ~HS_POL when deasserted; vsync SHALL follow VS_POL the same way.
REQ-023 Disable: en=0 SHALL synchronously do all of the following on the next edge:
- clear hc and vc to 0;
- flush every pipeline stage to idle (req=de=sof=eol=0, syncs deasserted, x=y=0).
REQ-024 Restart: the first cycle with en=1 after en=0 SHALL count hc=0,vc=0, so sof appears at stage 0 one cycle later.
REQ-025 Counter width: counters SHALL never exceed H_TOTAL-1 or V_TOTAL-1; CW SHALL satisfy 2^CW >= max(H_TOTAL,V_TOTAL), with an elaboration-time error otherwise.

Reset
REQ-026 On rst: hc=vc=0, all pipeline stages idle, req=de=sof=eol=0, x=y=0, hsync=~HS_POL, vsync=~VS_POL.
REQ-027 Release: the first count SHALL occur on the first edge with rst=0 and en=1; rst SHALL dominate en.
REQ-028 Mid-frame reset: rst asserted mid-frame SHALL abort the frame with no partial pulse emitted after release.

Structure
REQ-029 Package vga_timing_pkg SHALL hold the 640x480@60 default constants, H_TOTAL/V_TOTAL computation functions and the polarity constants.
REQ-030 Sub-module vga_delay_line SHALL implement the parametric PIPE-deep shift register with width, async rst and sync flush; it is instantiated once for the 5-bit output bundle.

Verification
REQ-031 Test configuration: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), PIPE=2, polarities 0.
REQ-032 Reset then en=1 -> sof at stage 0 one cycle after en rises; de high for 4 cycles, 2 cycles after req; frame period 48 cycles.
REQ-033 Sync windows -> hsync low for hc 5..6; vsync low for exactly 8 cycles (vc=4); x runs 0..3 while req=1.
REQ-034 HS_POL=1, VS_POL=1 -> same windows with hsync/vsync high; idle level low after reset.
REQ-035 en dropped at hc=2,vc=1 for 3 cycles -> outputs idle next edge, pipeline empty; restart gives sof and a full 48-cycle frame.
REQ-036 rst pulsed mid-line while en=1 -> outputs reach reset values with no clock; no stray eol or de after release.
